// File: rtl/byte_mem_word_arbiter.sv
// Two-requester word-access arbiter in front of a 256x8 byte memory.
// Each granted word transaction moves four bytes, little-endian, from
// consecutive byte addresses (wrapping at 0xFF). Priority alternates
// between the requesters after every completed transaction.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; requests are sampled only here
// ACCESS | four byte cycles, counter k selects byte/address offset
// DONE   | one-cycle Ack to the granted requester, then back to IDLE
module byte_mem_word_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        We0,
    input  logic        We1,
    input  logic [7:0]  Addr0,
    input  logic [7:0]  Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic [7:0]  MemAddress,
    output logic [7:0]  MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [7:0]  MemReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  k;
    logic        prio;
    logic        gnt;
    logic        gnt_nxt;
    logic        any_req;
    logic        we_l;
    logic [7:0]  addr_l;
    logic [31:0] wdata_l;
    logic [31:0] rdata;

    // Arbitration: sole requester wins, otherwise the priority holder wins
    always_comb begin
        any_req = Req0 | Req1;
        if (Req0 && Req1)
            gnt_nxt = prio;
        else
            gnt_nxt = Req1;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and memory/handshake outputs; everything idles at zero outside ACCESS
    always_comb begin
        state_nxt    = state;
        Busy         = 1'b0;
        Ack0         = 1'b0;
        Ack1         = 1'b0;
        MemAddress   = 8'd0;
        MemWriteData = 8'd0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                Busy       = 1'b1;
                MemAddress = addr_l + {6'd0, k};
                if (we_l) begin
                    MemWrite     = 1'b1;
                    MemWriteData = wdata_l[{k, 3'b000} +: 8];
                end else begin
                    MemRead = 1'b1;
                end
                if (k == 2'd3)
                    state_nxt = DONE;
            end
            DONE: begin
                Busy      = 1'b1;
                Ack0      = ~gnt;
                Ack1      = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ReadData = rdata;

    // Request latch, byte counter, read assembly and round-robin priority
    always_ff @(posedge Clk) begin
        if (Reset) begin
            k       <= 2'd0;
            prio    <= RR_INIT;
            gnt     <= 1'b0;
            we_l    <= 1'b0;
            addr_l  <= 8'd0;
            wdata_l <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= gnt_nxt;
                        k       <= 2'd0;
                        we_l    <= gnt_nxt ? We1 : We0;
                        addr_l  <= gnt_nxt ? Addr1 : Addr0;
                        wdata_l <= gnt_nxt ? WData1 : WData0;
                    end
                end
                ACCESS: begin
                    if (!we_l)
                        rdata[{k, 3'b000} +: 8] <= MemReadData;
                    k <= k + 2'd1;
                end
                DONE: begin
                    // Priority passes on even if the other side is not waiting
                    prio <= ~gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/byte_mem_word_arbiter.md
BYTE_MEM_WORD_ARBITER -- requirements
Module: byte_mem_word_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: the requester (0 or 1) that holds priority after reset.
REQ-002 SHALL have ports Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports Req0/Req1, input, 1 each: word-access request from requester 0/1.
REQ-005 SHALL have ports We0/We1, input, 1 each: 1 = word write, 0 = word read.
REQ-006 SHALL have ports Addr0/Addr1, input, 8 each: byte address of word byte 0.
REQ-007 SHALL have ports WData0/WData1, input, 32 each: write word.
REQ-008 SHALL have ports Ack0/Ack1, output, 1 each: one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have port ReadData, output, 32: assembled read word, shared by both requesters.
REQ-010 SHALL have port Busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have ports MemAddress, output, 8 / MemWriteData, output, 8 / MemWrite, output, 1 / MemRead, output, 1: drive the 256x8 byte memory (write on rising Clk, combinational read).
REQ-012 SHALL have port MemReadData, input, 8: the memory's combinational read data.

Function
REQ-013 SHALL implement states IDLE, ACCESS, DONE, with a 2-bit byte counter k used in ACCESS.
REQ-014 SHALL sample Req0/Req1 only in IDLE; at an edge where either is high, SHALL grant, latch the granted requester's We, Addr and WData, set k=0, and go to ACCESS.
REQ-015 SHALL grant the sole requester when one Req is high; when both are high, SHALL grant the priority holder.
REQ-016 SHALL pass priority to the other requester after each completed transaction (round-robin), whether or not that requester is waiting.
REQ-017 In ACCESS, SHALL drive MemAddress = (latched Addr + k) mod 256, so the address wraps 0xFF->0x00.
REQ-018 For writes, in ACCESS SHALL drive MemWrite=1, MemRead=0 and MemWriteData = latched WData[8k+7:8k] (little-endian).
REQ-019 For reads, in ACCESS SHALL drive MemRead=1, MemWrite=0, and SHALL capture MemReadData into ReadData[8k+7:8k] at each ACCESS edge.
REQ-020 SHALL increment k at each ACCESS edge and go to DONE at the edge where k=3; ACCESS lasts exactly 4 cycles.
REQ-021 In DONE, SHALL assert Ack of the granted requester only, for exactly one cycle, then return to IDLE.
REQ-022 Outside ACCESS, SHALL drive MemWrite=0, MemRead=0, MemAddress=0 and MemWriteData=0.
REQ-023 ReadData SHALL hold its value from the last completed read until the next read captures byte 0; write transactions SHALL NOT alter it.
REQ-024 Latency: Req sampled high at edge E0 yields Ack high during the cycle after E4, i.e. 5 cycles after E0; throughput is one word per 6 cycles when requests are back-to-back.
REQ-025 Requester inputs SHALL be don't-care after grant; a requester SHALL drop Req during its Ack cycle, and a Req still high at the next IDLE sample SHALL be treated as a new request.
REQ-026 Arbiter SHALL never assert MemWrite and MemRead in the same cycle, and SHALL never assert Ack0 and Ack1 together.

Reset
REQ-027 Reset high at an edge SHALL force state=IDLE, k=0, priority=RR_INIT, Ack0=Ack1=0, Busy=0, ReadData=0, and all Mem* outputs =0, overriding any request in that cycle.
REQ-028 Reset during ACCESS SHALL abort the transaction with no Ack; bytes already written SHALL remain written, and no further bytes SHALL be written.

Verification
REQ-029 Write then read: Req0, We0=1, Addr0=0x10, WData0=0xDEADBEEF -> mem[0x10..0x13]=EF,BE,AD,DE and Ack0 at E0+5; then Req1 read at 0x10 -> ReadData=0xDEADBEEF with Ack1.
REQ-030 Wrap: write 0x11223344 at Addr=0xFE -> mem[0xFE]=44, mem[0xFF]=33, mem[0x00]=22, mem[0x01]=11.
REQ-031 Contention: Req0 and Req1 held high continuously from reset (RR_INIT=0) -> grants alternate 0,1,0,1; Acks spaced 6 cycles apart; never both Acks high.
REQ-032 Reset mid-write: assert Reset at the ACCESS edge where k=1 -> only byte 0 (and byte 1 if written at that edge) changed, no Ack, Busy=0 next cycle, all outputs at reset values.
REQ-033 Idle hygiene: no Req for 20 cycles -> MemWrite=MemRead=0 and Busy=0 throughout; ReadData unchanged.
